// File: rtl/fir_mac_engine.sv
// rtl/fir_mac_engine.sv - sequential single-MAC FIR engine over a circular delay line
// Reads one ROM coefficient per clock and accumulates TAPS products per output sample.
module fir_mac_engine #(
  parameter int TAPS        = 64,
  parameter int ADDR_WIDTH  = $clog2(TAPS),
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_WIDTH-1:0]  in_data,
  output logic        [ADDR_WIDTH-1:0]  coeff_address,
  input  logic signed [COEFF_WIDTH-1:0] coeff_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [ACC_WIDTH-1:0]   out_data
);

  localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_TAP  = ADDR_WIDTH'(TAPS - 1);
  localparam logic [ADDR_WIDTH-1:0] TAPS_ADDR = ADDR_WIDTH'(TAPS);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                        state, state_next;
  logic signed [DATA_WIDTH-1:0]  delay_line [TAPS];
  logic        [ADDR_WIDTH-1:0]  wr_ptr, newest, tap, rd_idx;
  logic signed [ACC_WIDTH-1:0]   acc, product_ext;
  logic signed [PROD_WIDTH-1:0]  product;
  logic signed [DATA_WIDTH-1:0]  sample;

  // Index wraps at TAPS, which need not be a power of two.
  always_comb begin
    rd_idx = (newest >= tap) ? (newest - tap) : (TAPS_ADDR + newest - tap);
    sample = delay_line[rd_idx];
    product = sample * coeff_data;
    product_ext = {{(ACC_WIDTH - PROD_WIDTH){product[PROD_WIDTH-1]}}, product};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = MAC;
      MAC:     if (tap == LAST_TAP) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready      = (state == IDLE);
  assign out_valid     = (state == DONE);
  assign out_data      = (state == DONE) ? acc : '0;
  assign coeff_address = (state == MAC) ? tap : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      tap    <= '0;
      wr_ptr <= '0;
      newest <= '0;
      for (int i = 0; i < TAPS; i++) delay_line[i] <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            delay_line[wr_ptr] <= in_data;
            newest             <= wr_ptr;
            acc                <= '0;
            tap                <= '0;
          end
        end
        MAC: begin
          acc <= acc + product_ext;
          tap <= tap + ONE;
          if (tap == LAST_TAP) wr_ptr <= (newest == LAST_TAP) ? '0 : newest + ONE;
        end
        default: ;
      endcase
    end
  end

endmodule
